// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the ROM.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/if_stage.sv
// PA-RISC instruction fetch: PC/nPC pair, IF/ID register, stall/redirect.
// Define IF_PERF_CNT_EN to build the fetch/stall performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le,
  input  logic        tak,
  input  logic [31:0] ta,
  input  logic        nullify,
  if_stage_if.master  imem,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_ta_q, pend_ta_d;
  logic [31:0] ta_al;
  logic        redir;
  logic [31:0] redir_ta;

  assign ta_al    = ta & ~32'h3;
  assign redir    = tak | pend_q;
  assign redir_ta = tak ? ta_al : pend_ta_q;

  always_comb begin
    pc_d      = pc_q;
    npc_d     = npc_q;
    instr_d   = instr_q;
    ifpc_d    = ifpc_q;
    pend_d    = pend_q;
    pend_ta_d = pend_ta_q;
    if (le) begin
      instr_d = nullify ? 32'h0 : imem.imem_data;
      ifpc_d  = pc_q;
      pc_d    = npc_q;
      npc_d   = redir ? redir_ta : npc_q + 32'd4;
      pend_d  = 1'b0;
    end else begin
      if (nullify) instr_d = 32'h0;
      // Remember a branch resolved while stalled
      if (tak) begin
        pend_d    = 1'b1;
        pend_ta_d = ta_al;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      npc_q     <= RESET_PC + 32'd4;
      instr_q   <= 32'h0;
      ifpc_q    <= 32'h0;
      pend_q    <= 1'b0;
      pend_ta_q <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      instr_q   <= instr_d;
      ifpc_q    <= ifpc_d;
      pend_q    <= pend_d;
      pend_ta_q <= pend_ta_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (le && !nullify) fcnt_d = fcnt_q + 32'd1;
    if (!le) scnt_d = scnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= 32'h0;
      scnt_q <= 32'h0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign stall_cnt = scnt_q;
`else
  assign fetch_cnt = 32'h0;
  assign stall_cnt = 32'h0;
`endif

  assign imem.imem_addr = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign pc             = pc_q;
  assign npc            = npc_q;

endmodule
